// File: rtl/axi_demo_wr_joiner_pkg.sv
// axi_demo_wr_joiner_pkg
//   Shared AXI demo types: address/data/strobe widths and aliases, the
//   write-response encoding, the register-write request record and the
//   joiner FSM state encoding.
package axi_demo_wr_joiner_pkg;

  localparam int AXI_ADDRESS_WIDTH = 32;
  localparam int AXI_DATA_WIDTH    = 32;
  localparam int AXI_STROBE_WIDTH  = AXI_DATA_WIDTH / 8;

  typedef logic [AXI_ADDRESS_WIDTH-1:0] axiAddrT;
  typedef logic [AXI_DATA_WIDTH-1:0]    axiDataT;
  typedef logic [AXI_STROBE_WIDTH-1:0]  axiStrobeT;

  typedef axiAddrT   axiAddrSt;
  typedef axiDataT   axiDataSt;
  typedef axiStrobeT axiStrobeSt;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axiRespT;

  typedef struct packed {
    axiAddrT   addr;
    axiDataT   data;
    axiStrobeT strobe;
  } regWrReqSt;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } wrJoinStateT;

  // The register file is word-addressed; byte offset bits are dropped.
  function automatic axiAddrT word_align(input axiAddrT a);
    return {a[AXI_ADDRESS_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/axi_demo_sync_fifo.sv
// axi_demo_sync_fifo
//   Small single-clock FIFO, show-ahead (o_rdata is the current head).
//   Ports:
//     clk, rst      clock, async active-high reset (empties the FIFO)
//     i_push        write request, ignored when full
//     i_wdata       write data
//     i_pop         read request, ignored when empty
//     o_rdata       head entry (valid when !o_empty)
//     o_full        no free entry
//     o_empty       no stored entry
module axi_demo_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when indices match.
  logic [PW:0]      r_wptr, r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push, w_pop;

  assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/axi_demo_wr_joiner.sv
// axi_demo_wr_joiner
//   Joins independent AXI4-Lite AW and W channels (each buffered in its own
//   FIFO) into single register-write requests and returns one B response per
//   joined pair, in arrival order.
//   Optional build macro: AXIDEMO_WR_ADDR_CHECK_EN -- pairs whose address is
//   >= REG_ADDR_LIMIT are not written and answered with SLVERR.
//   Ports:
//     clk, rst                          clock, async active-high reset
//     aw_valid/aw_ready/aw_addr         write-address channel
//     w_valid/w_ready/w_data/w_strb     write-data channel
//     reg_wr_valid/ready/addr/data/strb register write request
//     b_valid/b_ready/b_resp            write response
module axi_demo_wr_joiner
  import axi_demo_wr_joiner_pkg::*;
#(
  parameter int      AW_DEPTH       = 2,
  parameter int      W_DEPTH        = 2,
  parameter axiAddrT REG_ADDR_LIMIT = 32'h0000_1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       aw_valid,
  output logic       aw_ready,
  input  axiAddrSt   aw_addr,
  input  logic       w_valid,
  output logic       w_ready,
  input  axiDataSt   w_data,
  input  axiStrobeSt w_strb,
  output logic       reg_wr_valid,
  input  logic       reg_wr_ready,
  output axiAddrT    reg_wr_addr,
  output axiDataT    reg_wr_data,
  output axiStrobeT  reg_wr_strb,
  output logic       b_valid,
  input  logic       b_ready,
  output logic [1:0] b_resp
);

`ifdef AXIDEMO_WR_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  localparam int WW = AXI_STROBE_WIDTH + AXI_DATA_WIDTH;

  logic        w_aw_full, w_aw_empty;
  axiAddrT     w_aw_head;
  logic        w_w_full, w_w_empty;
  logic [WW-1:0] w_w_head;
  logic        w_pop, w_range_err;
  axiStrobeT   w_head_strb;

  wrJoinStateT r_state;
  regWrReqSt   r_req;
  logic        r_wr_valid, r_b_valid;
  axiRespT     r_resp;

  assign aw_ready = !w_aw_full;
  assign w_ready  = !w_w_full;

  axi_demo_sync_fifo #(.WIDTH(AXI_ADDRESS_WIDTH), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (aw_valid),
    .i_wdata (aw_addr),
    .i_pop   (w_pop),
    .o_rdata (w_aw_head),
    .o_full  (w_aw_full),
    .o_empty (w_aw_empty)
  );

  axi_demo_sync_fifo #(.WIDTH(WW), .DEPTH(W_DEPTH)) u_w_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_valid),
    .i_wdata ({w_strb, w_data}),
    .i_pop   (w_pop),
    .o_rdata (w_w_head),
    .o_full  (w_w_full),
    .o_empty (w_w_empty)
  );

  // Both heads leave together, and only while nothing is in flight.
  assign w_pop       = (r_state == IDLE) && !w_aw_empty && !w_w_empty;
  assign w_head_strb = w_w_head[WW-1:AXI_DATA_WIDTH];
  // Range check on the raw byte address; constant-false when disabled.
  assign w_range_err = ADDR_CHECK && (w_aw_head >= REG_ADDR_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_req      <= '0;
      r_wr_valid <= 1'b0;
      r_b_valid  <= 1'b0;
      r_resp     <= OKAY;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_req.addr   <= word_align(w_aw_head);
            r_req.data   <= w_w_head[AXI_DATA_WIDTH-1:0];
            r_req.strobe <= w_head_strb;
            if (w_range_err) begin
              r_b_valid <= 1'b1;
              r_resp    <= SLVERR;
              r_state   <= RESP;
            end else if (w_head_strb == '0) begin
              // Nothing to write: acknowledge without touching the register file.
              r_b_valid <= 1'b1;
              r_resp    <= OKAY;
              r_state   <= RESP;
            end else begin
              r_wr_valid <= 1'b1;
              r_state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (reg_wr_ready) begin
            r_wr_valid <= 1'b0;
            r_b_valid  <= 1'b1;
            r_resp     <= OKAY;
            r_state    <= RESP;
          end
        end
        RESP: begin
          if (b_ready) begin
            r_b_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign reg_wr_valid = r_wr_valid;
  assign reg_wr_addr  = r_req.addr;
  assign reg_wr_data  = r_req.data;
  assign reg_wr_strb  = r_req.strobe;
  assign b_valid      = r_b_valid;
  assign b_resp       = r_resp;

endmodule

// File: doc/axi_demo_wr_joiner.md
Name: axi_demo_wr_joiner

Overview:
- Downstream consumer of the axiDemo address, data and strobe types.
- Accepts an AXI4-Lite style write-address (AW) channel and write-data (W) channel independently, each through its own small FIFO.
- Pairs one AW with one W and issues a single register write on a valid/ready request port.
- Returns one write response (B) per completed pair; sits between the AXI slave port and the demo register file.

Parameters:
- AW_DEPTH, 2, AW FIFO entries (power of 2, >=2)
- W_DEPTH, 2, W FIFO entries (power of 2, >=2)
- REG_ADDR_LIMIT, 32'h0000_1000, first byte address outside the register space (used only with the optional feature)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- aw_valid  in  1  AW valid
- aw_ready  out  1  AW ready; high when AW FIFO not full
- aw_addr  in  32  axiAddrSt
- w_valid  in  1  W valid
- w_ready  out  1  W ready; high when W FIFO not full
- w_data  in  32  axiDataSt
- w_strb  in  4  axiStrobeSt
- reg_wr_valid  out  1  register write request valid
- reg_wr_ready  in  1  register write accept
- reg_wr_addr  out  32  word address, bits [1:0] forced to 0
- reg_wr_data  out  32  write data
- reg_wr_strb  out  4  byte enables
- b_valid  out  1  response valid
- b_ready  in  1  response accept
- b_resp  out  2  2'b00 OKAY, 2'b10 SLVERR

Behaviour:
- Reset (async assert, sync-released use): FIFOs empty, FSM=IDLE, aw_ready=1, w_ready=1, reg_wr_valid=0, b_valid=0, b_resp=0, reg_wr_addr/data/strb=0.
- FIFOs: push on valid&ready; pop only by FSM; a push and pop in the same cycle on a full FIFO is not allowed (ready already 0); on a non-empty, non-full FIFO the count is unchanged. Pointers are log2(DEPTH)+1 bits, wrap naturally; full = MSBs differ and LSBs equal.
- FSM IDLE: when both FIFOs non-empty -> pop both heads, register addr/data/strb.
  - strb != 0 -> ISSUE.
  - strb == 0 -> RESP with OKAY, no register write.
- ISSUE: reg_wr_valid=1; outputs held stable until reg_wr_ready. On handshake -> RESP, b_resp=OKAY.
- RESP: b_valid=1, b_resp held stable until b_ready. On handshake -> IDLE. No new pair is popped while in ISSUE or RESP.
- Latency: AW and W accepted in cycle N into empty FIFOs -> reg_wr_valid in N+2. With reg_wr_ready tied high -> b_valid in N+3.
- AW arriving many beats ahead of W (or the reverse): held in its FIFO; the opposite FIFO keeps accepting until full.
- Ordering: responses are in strict AW/W arrival order.
- Reset mid-operation: all in-flight pairs are dropped, with no response generated.

Optional Feature:
- Macro: AXIDEMO_WR_ADDR_CHECK_EN.
- Defined: in IDLE, a popped pair with aw_addr >= REG_ADDR_LIMIT skips ISSUE and goes to RESP with b_resp=SLVERR (2'b10). The register write is suppressed regardless of strb.
- Undefined: no range check; b_resp is always OKAY and REG_ADDR_LIMIT is unused.

Decomposition:
- axiDemo package supplies AXI_ADDRESS_WIDTH, AXI_DATA_WIDTH, AXI_STROBE_WIDTH, axiAddrSt, axiDataSt and axiStrobeSt.
- Add to the package:
  - enum axiRespT (OKAY=2'b00, SLVERR=2'b10)
  - struct regWrReqSt {axiAddrT addr; axiDataT data; axiStrobeT strobe;}
  - enum wrJoinStateT {IDLE, ISSUE, RESP}
- One sub-module: axi_demo_sync_fifo (parameterised width/depth), instantiated twice: AW (32b) and W (36b).

Test Plan:
- Single write: AW 0x0000_0010 and W 0xDEAD_BEEF/strb 0xF in the same cycle, ready high -> reg_wr addr 0x10, data 0xDEADBEEF two cycles later; b_resp OKAY one cycle after that.
- AW skew: three AWs (0x0, 0x4, 0x8) with no W -> aw_ready drops after 2 accepted; then 2 Ws (0x1, 0x2) -> writes 0x0/0x1 then 0x4/0x2 in order; the third AW is accepted once space frees.
- Backpressure: reg_wr_ready low 5 cycles, then b_ready low 3 cycles -> request and response fields stable throughout; exactly one B issued.
- Zero strobe: AW 0x20, W 0x1234_5678/strb 0x0 -> no reg_wr_valid pulse; b_valid with OKAY.
- Reset mid-ISSUE: assert rst while reg_wr_valid=1 -> reg_wr_valid and b_valid go to 0 immediately; FIFOs empty; no B after release.
- With AXIDEMO_WR_ADDR_CHECK_EN: AW 0x0000_1000, strb 0xF -> no register write; b_resp 2'b10. AW 0x0000_0FFC -> written, OKAY.
